approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
- Receiving and checking end of the approximate-adder test path: consumes {A, B, approximate sum} triples from the adder under test.
- Computes the exact sum and the signed error distance ED = (A+B) - result.
- Accumulates error statistics over a fixed window of samples, then presents one report through a valid/ready handshake.
- Replaces the simulation-only checker with synthesizable on-chip error characterisation.

Parameters:
- N, 16, operand width of the adder under test.
- WIN_LOG2, 8, log2 of the samples per report window (window = 2^WIN_LOG2).
- ACC_W, N+1+WIN_LOG2, width of the |ED| accumulator (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clear  in  1  synchronous abort: zero statistics and start a new window.
- in_valid  in  1  sample present.
- in_ready  out  1  monitor accepts a sample; transfer occurs when in_valid && in_ready.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_res  in  N+1  approximate sum from the adder under test.
- rpt_valid  out  1  report present.
- rpt_ready  in  1  report consumed on rpt_valid && rpt_ready.
- rpt_err_count  out  WIN_LOG2+1  number of samples with ED != 0.
- rpt_sum_abs_ed  out  ACC_W  sum of |ED|.
- rpt_sum_ed  out  ACC_W+1  signed sum of ED (bias).
- rpt_max_abs_ed  out  N+1  maximum |ED| in the window.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=0, rpt_valid=0, all rpt_* = 0, pipeline and accumulators zeroed, state ACCUM. in_ready rises at the first clk edge after rst_n deasserts.
- Width rules:
  - Exact sum is N+1 bits.
  - ED is an N+2-bit signed value computed without overflow. Range: -(2^(N+1)-1) to 2^(N+1)-2.
  - |ED| is N+1 bits unsigned.
  - Accumulators are sized so a full window cannot overflow. No saturation logic.
- Pipeline:
  - S1 registers ED for each accepted sample.
  - S2 updates err_count, sum_abs, sum_ed and max_abs from S1.
  - An accepted sample is reflected in the accumulators 2 edges after acceptance.
- States:
  - ACCUM:
    - in_ready=1; an accept counter increments on each transfer.
    - On the transfer that makes the count 2^WIN_LOG2, in_ready drops at that same edge. Go to DRAIN.
  - DRAIN:
    - Waits one edge so the final sample retires through S2.
    - At the next edge, copy accumulators to the rpt_* registers, set rpt_valid=1, go to REPORT.
  - REPORT:
    - rpt_valid=1 and rpt_* are held stable until rpt_ready.
    - On handshake: rpt_valid=0, accumulators and counter zeroed, in_ready=1 at that same edge, go to ACCUM.
    - rpt_* keep their last values after the handshake; they are only meaningful while rpt_valid=1.
- Timing: the last accept at edge k gives rpt_valid=1 after edge k+2. The first new sample can be accepted on the edge after the report handshake.
- in_valid while in_ready=0 is ignored. The sender must hold its data, per handshake rules.
- clear (any state):
  - At the next edge: pipeline, accumulators and counter are zeroed; rpt_valid=0 (a pending report is dropped); state ACCUM; in_ready=1.
  - A sample presented in the same cycle as clear is discarded.
  - clear takes priority over rpt_ready.
- Async reset mid-operation: all outputs return to reset values immediately. The partial window is lost.
- max_abs uses a strictly-greater compare; equal values leave it unchanged.

Decomposition:
- Package approx_pkg holds:
  - the default N and WIN_LOG2 values;
  - a state enum {ACCUM, DRAIN, REPORT};
  - an ed_t typedef (signed N+2).
- One sub-module, approx_ed_calc: combinational exact sum, ED, |ED| and the ed_nonzero flag, instantiated ahead of the S1 register.
- The FSM, counter and accumulators stay in the top.

Test Plan:
All scenarios use N=16, WIN_LOG2=2 (4-sample window).
1. Four samples (2,1,3), rpt_ready=1 -> rpt_valid=1 two edges after the 4th accept; err_count=0, sum_abs=0, sum_ed=0, max_abs=0.
2. Samples (2,1,3), (100,200,296), (65535,65535,131071), (0,0,8), giving ED 0,+4,-1,-8 -> err_count=3, sum_abs=13, sum_ed=-5, max_abs=8.
3. Extremes (0,0,131071)x2 and (65535,65535,0)x2 -> sum_abs=524282, sum_ed=-2, max_abs=131071, err_count=4.
4. Backpressure: scenario 2 with rpt_ready=0 for 10 cycles while in_valid=1 with new data -> rpt_valid and rpt_* stable, in_ready=0, no sample counted. After rpt_ready=1, in_ready=1 the same edge, and the next window starts from zero.
5. Two samples of scenario 2, pulse clear, then four exact samples (2,1,3) -> report err_count=0, sum_abs=0 (pre-clear data discarded).
6. Assert rst_n=0 while rpt_valid=1 -> rpt_valid=0 and in_ready=0 immediately. After release, in_ready=1 at the first edge, and a fresh scenario 1 reproduces its result.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   N_DEF        : default operand width of the adder under test
//   WIN_LOG2_DEF : default log2 of samples per report window
//   state_e      : monitor FSM states
//   ed_t         : signed error distance at the default width
package approx_pkg;

  localparam int unsigned N_DEF        = 16;
  localparam int unsigned WIN_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Wide enough that (A+B) - result never overflows.
  typedef logic signed [N_DEF+1:0] ed_t;

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample/report bus of the approximate-adder error monitor.
//   clear          : synchronous abort, restarts the window
//   in_valid/ready : sample handshake carrying in_a, in_b, in_res
//   rpt_valid/ready: report handshake carrying the rpt_* statistics
// master: the side feeding samples and consuming reports.
// slave : the monitor.
interface approx_err_monitor_if
  import approx_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) ();

  localparam int unsigned ACC_W = N + 1 + WIN_LOG2;

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0]            in_a;
  logic [N-1:0]            in_b;
  logic [N:0]              in_res;
  logic                    rpt_valid;
  logic                    rpt_ready;
  logic [WIN_LOG2:0]       rpt_err_count;
  logic [ACC_W-1:0]        rpt_sum_abs_ed;
  logic signed [ACC_W:0]   rpt_sum_ed;
  logic [N:0]              rpt_max_abs_ed;

  modport master (
    output clear, in_valid, in_a, in_b, in_res, rpt_ready,
    input  in_ready, rpt_valid, rpt_err_count, rpt_sum_abs_ed, rpt_sum_ed, rpt_max_abs_ed
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, in_res, rpt_ready,
    output in_ready, rpt_valid, rpt_err_count, rpt_sum_abs_ed, rpt_sum_ed, rpt_max_abs_ed
  );

endinterface

// File: rtl/approx_ed_calc.sv
// Combinational error-distance calculation for one sample.
//   i_a, i_b      : operands of the adder under test
//   i_res         : approximate sum produced by the adder under test
//   o_ed          : signed ED = (i_a + i_b) - i_res, N+2 bits
//   o_abs_ed      : |ED|, N+1 bits
//   o_ed_nonzero  : ED != 0
module approx_ed_calc
  import approx_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0]        i_a,
  input  logic [N-1:0]        i_b,
  input  logic [N:0]          i_res,
  output logic signed [N+1:0] o_ed,
  output logic [N:0]          o_abs_ed,
  output logic                o_ed_nonzero
);

  localparam logic [N:0] AbsOne = {{N{1'b0}}, 1'b1};

  logic [N:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Both operands zero-extended to N+2 bits, so the difference cannot overflow.
  assign o_ed = $signed({1'b0, w_sum}) - $signed({1'b0, i_res});

  // Largest magnitude is 2^(N+1)-1, so the low N+1 bits of the negation suffice.
  assign o_abs_ed = o_ed[N+1] ? (~o_ed[N:0] + AbsOne) : o_ed[N:0];

  assign o_ed_nonzero = |o_ed;

endmodule

// File: rtl/approx_err_monitor.sv
// On-chip error characterisation for an approximate adder.
// Accepts {A, B, result} samples, computes the error distance and accumulates
// error count, sum |ED|, signed sum ED and max |ED| over 2^WIN_LOG2 samples,
// then offers one report over a valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sample input, clear and report output (slave side)
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_err_monitor_if.slave bus
);

  localparam int unsigned ACC_W = N + 1 + WIN_LOG2;

  localparam logic [WIN_LOG2-1:0] CntOne = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  // Combinational ED of the sample on the bus.
  logic signed [N+1:0] w_ed;
  logic [N:0]          w_abs_ed;
  logic                w_ed_nonzero;

  // Handshake and FSM decode.
  logic   w_xfer;
  logic   w_last;
  state_e w_state_d;
  logic   w_in_ready_d;
  logic   w_rpt_valid_d;
  logic   w_rpt_load;
  logic   w_acc_clr;

  // S2 operands aligned to accumulator widths.
  logic [ACC_W:0]    w_ed_ext;
  logic [ACC_W-1:0]  w_abs_ext;
  logic [WIN_LOG2:0] w_nz_ext;

  state_e              r_state;
  logic                r_in_ready;
  logic [WIN_LOG2-1:0] r_cnt;

  logic                r_s1_valid;
  logic signed [N+1:0] r_s1_ed;
  logic [N:0]          r_s1_abs;
  logic                r_s1_nz;

  logic [WIN_LOG2:0]   r_err_count;
  logic [ACC_W-1:0]    r_sum_abs;
  logic [ACC_W:0]      r_sum_ed;
  logic [N:0]          r_max_abs;

  logic                r_rpt_valid;
  logic [WIN_LOG2:0]   r_rpt_err_count;
  logic [ACC_W-1:0]    r_rpt_sum_abs;
  logic [ACC_W:0]      r_rpt_sum_ed;
  logic [N:0]          r_rpt_max_abs;

  approx_ed_calc #(
    .N (N)
  ) u_ed_calc (
    .i_a          (bus.in_a),
    .i_b          (bus.in_b),
    .i_res        (bus.in_res),
    .o_ed         (w_ed),
    .o_abs_ed     (w_abs_ed),
    .o_ed_nonzero (w_ed_nonzero)
  );

  // A sample presented alongside clear is discarded.
  assign w_xfer = bus.in_valid & r_in_ready & ~bus.clear;
  assign w_last = (r_cnt == {WIN_LOG2{1'b1}});

  always_comb begin
    w_state_d     = r_state;
    w_in_ready_d  = r_in_ready;
    w_rpt_valid_d = r_rpt_valid;
    w_rpt_load    = 1'b0;
    w_acc_clr     = 1'b0;
    if (bus.clear) begin
      w_state_d     = ACCUM;
      w_in_ready_d  = 1'b1;
      w_rpt_valid_d = 1'b0;
      w_acc_clr     = 1'b1;
    end else begin
      unique case (r_state)
        ACCUM: begin
          w_in_ready_d = 1'b1;
          if (w_xfer && w_last) begin
            w_in_ready_d = 1'b0;
            w_state_d    = DRAIN;
          end
        end
        DRAIN: begin
          w_in_ready_d = 1'b0;
          // S1 still holds the final sample on the first DRAIN cycle; report once it retired.
          if (!r_s1_valid) begin
            w_rpt_load    = 1'b1;
            w_rpt_valid_d = 1'b1;
            w_state_d     = REPORT;
          end
        end
        REPORT: begin
          if (bus.rpt_ready) begin
            w_rpt_valid_d = 1'b0;
            w_acc_clr     = 1'b1;
            w_in_ready_d  = 1'b1;
            w_state_d     = ACCUM;
          end
        end
        default: begin
          w_state_d    = ACCUM;
          w_in_ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= w_in_ready_d;
      if (w_acc_clr) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CntOne;
      end
    end
  end

  // S1: register the ED of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_s1_abs   <= '0;
      r_s1_nz    <= 1'b0;
    end else if (bus.clear) begin
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_s1_abs   <= '0;
      r_s1_nz    <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_ed  <= w_ed;
        r_s1_abs <= w_abs_ed;
        r_s1_nz  <= w_ed_nonzero;
      end
    end
  end

  assign w_ed_ext  = {{WIN_LOG2{r_s1_ed[N+1]}}, r_s1_ed};
  assign w_abs_ext = {{WIN_LOG2{1'b0}}, r_s1_abs};
  assign w_nz_ext  = {{WIN_LOG2{1'b0}}, r_s1_nz};

  // S2: fold the S1 sample into the window statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_sum_abs   <= '0;
      r_sum_ed    <= '0;
      r_max_abs   <= '0;
    end else if (w_acc_clr) begin
      r_err_count <= '0;
      r_sum_abs   <= '0;
      r_sum_ed    <= '0;
      r_max_abs   <= '0;
    end else if (r_s1_valid) begin
      r_err_count <= r_err_count + w_nz_ext;
      r_sum_abs   <= r_sum_abs + w_abs_ext;
      r_sum_ed    <= r_sum_ed + w_ed_ext;
      // Strictly greater: ties keep the existing maximum.
      if (r_s1_abs > r_max_abs) begin
        r_max_abs <= r_s1_abs;
      end
    end
  end

  // Report registers stay at their last values after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_valid     <= 1'b0;
      r_rpt_err_count <= '0;
      r_rpt_sum_abs   <= '0;
      r_rpt_sum_ed    <= '0;
      r_rpt_max_abs   <= '0;
    end else begin
      r_rpt_valid <= w_rpt_valid_d;
      if (w_rpt_load) begin
        r_rpt_err_count <= r_err_count;
        r_rpt_sum_abs   <= r_sum_abs;
        r_rpt_sum_ed    <= r_sum_ed;
        r_rpt_max_abs   <= r_max_abs;
      end
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.rpt_valid      = r_rpt_valid;
  assign bus.rpt_err_count  = r_rpt_err_count;
  assign bus.rpt_sum_abs_ed = r_rpt_sum_abs;
  assign bus.rpt_sum_ed     = r_rpt_sum_ed;
  assign bus.rpt_max_abs_ed = r_rpt_max_abs;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor with N=16, WIN_LOG2=2 (4-sample window).
// The stimulus process pushes hand-computed reports; a monitor pops and compares
// on every report handshake. Timing and stability checks are made inline.
module tb_approx_err_monitor;

  typedef struct {
    longint err;
    longint sum_abs;
    longint sum_ed;
    longint max_abs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  exp_t q[$];
  exp_t e_mon;

  // Window vectors {A, B, result}: 0 exact, 1 mixed ED 0,+4,-1,-8, 2 extremes.
  int unsigned tbl[3][4][3] = '{
    '{'{2, 1, 3}, '{2, 1, 3}, '{2, 1, 3}, '{2, 1, 3}},
    '{'{2, 1, 3}, '{100, 200, 296}, '{65535, 65535, 131071}, '{0, 0, 8}},
    '{'{0, 0, 131071}, '{0, 0, 131071}, '{65535, 65535, 0}, '{65535, 65535, 0}}
  };

  approx_err_monitor_if #(.N(16), .WIN_LOG2(2)) bus ();

  approx_err_monitor #(
    .N        (16),
    .WIN_LOG2 (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rpt(input longint err, input longint sa, input longint se,
                            input longint mx);
    exp_t e;
    e.err = err; e.sum_abs = sa; e.sum_ed = se; e.max_abs = mx;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int unsigned a, input int unsigned b, input int unsigned r);
    int c = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a[15:0];
    bus.in_b     = b[15:0];
    bus.in_res   = r[16:0];
    @(negedge clk);
    while (!bus.in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!bus.in_ready) chk("accept_wait", longint'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_win(input int id);
    for (int i = 0; i < 4; i++) send(tbl[id][i][0], tbl[id][i][1], tbl[id][i][2]);
  endtask

  task automatic wait_rpt_valid();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.rpt_valid && c < 20);
    chk("rpt_valid_wait", longint'(bus.rpt_valid), 1);
  endtask

  // Wait until the report has been taken and sampling resumed.
  task automatic finish_win();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.in_ready && c < 20);
    chk("window_done", longint'(bus.in_ready), 1);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rpt_valid && bus.rpt_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_report: got report err_count=%0d, expected none",
                 bus.rpt_err_count);
      end else begin
        e_mon = q.pop_front();
        chk("rpt_err_count", longint'(bus.rpt_err_count), e_mon.err);
        chk("rpt_sum_abs_ed", longint'(bus.rpt_sum_abs_ed), e_mon.sum_abs);
        chk("rpt_sum_ed", longint'(bus.rpt_sum_ed), e_mon.sum_ed);
        chk("rpt_max_abs_ed", longint'(bus.rpt_max_abs_ed), e_mon.max_abs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_res    = '0;
    bus.rpt_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_rpt_valid", longint'(bus.rpt_valid), 0);
    chk("rst_err_count", longint'(bus.rpt_err_count), 0);
    chk("rst_sum_abs", longint'(bus.rpt_sum_abs_ed), 0);
    chk("rst_sum_ed", longint'(bus.rpt_sum_ed), 0);
    chk("rst_max_abs", longint'(bus.rpt_max_abs_ed), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", longint'(bus.in_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", longint'(bus.in_ready), 1);
    tick();

    // 1: exact samples, report latency k+2
    expect_rpt(0, 0, 0, 0);
    send_win(0);
    @(negedge clk);
    chk("lat_k_valid", longint'(bus.rpt_valid), 0);
    chk("lat_k_ready", longint'(bus.in_ready), 0);
    @(negedge clk);
    chk("lat_k1_valid", longint'(bus.rpt_valid), 0);
    @(negedge clk);
    chk("lat_k2_valid", longint'(bus.rpt_valid), 1);
    finish_win();

    // 2: mixed errors
    expect_rpt(3, 13, -5, 8);
    send_win(1);
    finish_win();

    // 3: extremes
    expect_rpt(4, 524282, -2, 131071);
    send_win(2);
    finish_win();

    // 4: backpressure with new data offered
    bus.rpt_ready = 1'b0;
    expect_rpt(3, 13, -5, 8);
    send_win(1);
    wait_rpt_valid();
    tick();
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd7;
    bus.in_b     = 16'd7;
    bus.in_res   = 17'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rpt_valid", longint'(bus.rpt_valid), 1);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      chk("bp_err_count", longint'(bus.rpt_err_count), 3);
      chk("bp_sum_ed", longint'(bus.rpt_sum_ed), -5);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.rpt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_after_hs", longint'(bus.in_ready), 1);
    chk("bp_valid_after_hs", longint'(bus.rpt_valid), 0);
    tick();
    expect_rpt(0, 0, 0, 0);
    send_win(0);
    finish_win();

    // 5: clear discards a partial window and a coincident sample
    send(100, 200, 296);
    send(65535, 65535, 131071);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd0;
    bus.in_b     = 16'd0;
    bus.in_res   = 17'd8;
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", longint'(bus.in_ready), 1);
    chk("clr_rpt_valid", longint'(bus.rpt_valid), 0);
    tick();
    expect_rpt(0, 0, 0, 0);
    send_win(0);
    finish_win();

    // 6: async reset while a report is pending
    bus.rpt_ready = 1'b0;
    send_win(1);
    wait_rpt_valid();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rpt_valid", longint'(bus.rpt_valid), 0);
    chk("arst_in_ready", longint'(bus.in_ready), 0);
    chk("arst_err_count", longint'(bus.rpt_err_count), 0);
    chk("arst_max_abs", longint'(bus.rpt_max_abs_ed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready_pre_edge", longint'(bus.in_ready), 0);
    @(negedge clk);
    chk("arst_ready_post_edge", longint'(bus.in_ready), 1);
    bus.rpt_ready = 1'b1;
    tick();
    expect_rpt(0, 0, 0, 0);
    send_win(0);
    finish_win();

    repeat (3) tick();
    chk("pending_reports", longint'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
